mult_div_unit: RTL

//   E-stage multiply/divide unit of the P6 pipeline; owns the HI/LO registers.

---
 rtl/mult_div_unit.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/mult_div_unit.sv
// ----------------------------------------------------------------------------
// mult_div_unit
//   E-stage multiply/divide unit. Owns the architectural HI/LO registers and
//   models multi-cycle mult/div latency with a busy counter. Results are
//   computed at issue, held in pending registers and committed to HI/LO at
//   the end of the busy window.
//
// Ports
//   clk     in   1   system clock, all state on rising edge
//   reset   in   1   synchronous, active-high
//   md_op   in   4   0 none,1 mult,2 multu,3 div,4 divu,5 mthi,6 mtlo,
//                    7 mfhi,8 mflo; 9-15 none
//   rs_val  in   32  dividend / multiplicand / mthi-mtlo source
//   rt_val  in   32  divisor / multiplier
//   start   out  1   mult/div accepted this cycle (comb)
//   busy    out  1   operation in flight (registered)
//   hi      out  32  architectural HI
//   lo      out  32  architectural LO
//   md_out  out  32  mfhi -> hi, mflo -> lo, else 0 (comb)
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module mult_div_unit #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [3:0]  md_op,
   input  logic [31:0] rs_val,
   input  logic [31:0] rt_val,
   output logic        start,
   output logic        busy,
   output logic [31:0] hi,
   output logic [31:0] lo,
   output logic [31:0] md_out
);

   localparam int CNT_W = 16;
   localparam logic [CNT_W-1:0] MULT_LAST = CNT_W'(MULT_CYCLES - 1);
   localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(DIV_CYCLES - 1);

   localparam logic [3:0] OP_MULT  = 4'd1;
   localparam logic [3:0] OP_MULTU = 4'd2;
   localparam logic [3:0] OP_DIV   = 4'd3;
   localparam logic [3:0] OP_DIVU  = 4'd4;
   localparam logic [3:0] OP_MTHI  = 4'd5;
   localparam logic [3:0] OP_MTLO  = 4'd6;
   localparam logic [3:0] OP_MFHI  = 4'd7;
   localparam logic [3:0] OP_MFLO  = 4'd8;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_RUN  = 1'b1
   } state_t;

   state_t            state_q, state_d;
   logic              busy_q, busy_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic [31:0]       hi_q, hi_d;
   logic [31:0]       lo_q, lo_d;
   logic [31:0]       pend_hi_q, pend_hi_d;
   logic [31:0]       pend_lo_q, pend_lo_d;
   logic              pend_we_q, pend_we_d;

   logic              is_muldiv;
   logic              is_div;
   logic [63:0]       result;

   // Returns {hi, lo} of the signed 64-bit product.
   function automatic logic [63:0] mul_signed(input logic [31:0] a, input logic [31:0] b);
      logic signed [63:0] ax;
      logic signed [63:0] bx;
      logic signed [63:0] p;
      ax = {{32{a[31]}}, a};
      bx = {{32{b[31]}}, b};
      p  = ax * bx;
      return p;
   endfunction

   // Returns {hi, lo} of the unsigned 64-bit product.
   function automatic logic [63:0] mul_unsigned(input logic [31:0] a, input logic [31:0] b);
      logic [63:0] ax;
      logic [63:0] bx;
      ax = {32'd0, a};
      bx = {32'd0, b};
      return ax * bx;
   endfunction

   // Signed divide via magnitudes: quotient truncates toward zero, remainder
   // takes the dividend's sign. 0x80000000 / -1 falls out as lo=0x80000000,
   // hi=0 because the magnitude 2^31 negates back to itself.
   function automatic logic [63:0] div_signed(input logic [31:0] a, input logic [31:0] b);
      logic [31:0] ua;
      logic [31:0] ub;
      logic [31:0] q;
      logic [31:0] r;
      ua = a[31] ? -a : a;
      ub = b[31] ? -b : b;
      q  = (ub == 32'd0) ? 32'd0 : ua / ub;
      r  = (ub == 32'd0) ? 32'd0 : ua % ub;
      if (a[31] ^ b[31]) q = -q;
      if (a[31])         r = -r;
      return {r, q};
   endfunction

   // Returns {remainder, quotient} for unsigned divide.
   function automatic logic [63:0] div_unsigned(input logic [31:0] a, input logic [31:0] b);
      logic [31:0] q;
      logic [31:0] r;
      q = (b == 32'd0) ? 32'd0 : a / b;
      r = (b == 32'd0) ? 32'd0 : a % b;
      return {r, q};
   endfunction

   assign is_muldiv = (md_op == OP_MULT) || (md_op == OP_MULTU) ||
                      (md_op == OP_DIV)  || (md_op == OP_DIVU);
   assign is_div    = (md_op == OP_DIV)  || (md_op == OP_DIVU);
   assign start     = is_muldiv && !busy_q;

   always_comb begin
      result = 64'd0;
      case (md_op)
         OP_MULT:  result = mul_signed(rs_val, rt_val);
         OP_MULTU: result = mul_unsigned(rs_val, rt_val);
         OP_DIV:   result = div_signed(rs_val, rt_val);
         OP_DIVU:  result = div_unsigned(rs_val, rt_val);
         default:  result = 64'd0;
      endcase
   end

   always_comb begin
      state_d   = state_q;
      busy_d    = busy_q;
      count_d   = count_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      pend_hi_d = pend_hi_q;
      pend_lo_d = pend_lo_q;
      pend_we_d = pend_we_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d   = S_RUN;
               busy_d    = 1'b1;
               count_d   = is_div ? DIV_LAST : MULT_LAST;
               pend_hi_d = result[63:32];
               pend_lo_d = result[31:0];
               // Divide by zero keeps full timing but leaves HI/LO untouched.
               pend_we_d = !(is_div && (rt_val == 32'd0));
            end else if (md_op == OP_MTHI) begin
               hi_d = rs_val;
            end else if (md_op == OP_MTLO) begin
               lo_d = rs_val;
            end
         end
         S_RUN: begin
            // Everything presented while running is ignored; the hazard unit
            // holds the instruction in D until busy drops.
            if (count_q == '0) begin
               state_d = S_IDLE;
               busy_d  = 1'b0;
               if (pend_we_q) begin
                  hi_d = pend_hi_q;
                  lo_d = pend_lo_q;
               end
            end else begin
               count_d = count_q - 1'b1;
            end
         end
         default: begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= S_IDLE;
         busy_q    <= 1'b0;
         count_q   <= '0;
         hi_q      <= 32'd0;
         lo_q      <= 32'd0;
         pend_hi_q <= 32'd0;
         pend_lo_q <= 32'd0;
         pend_we_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         busy_q    <= busy_d;
         count_q   <= count_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
         pend_hi_q <= pend_hi_d;
         pend_lo_q <= pend_lo_d;
         pend_we_q <= pend_we_d;
      end
   end

   always_comb begin
      md_out = 32'd0;
      if (md_op == OP_MFHI) md_out = hi_q;
      else if (md_op == OP_MFLO) md_out = lo_q;
   end

   assign busy = busy_q;
   assign hi   = hi_q;
   assign lo   = lo_q;

endmodule
